// File: rtl/simple_pic.sv
// simple_pic: a reduced 8259-style programmable interrupt controller on a
// 16-bit Wishbone slave port.
//
// Ports
//   wb_clk_i          system clock, all state changes on its rising edge
//   wb_rst_i          synchronous active-high reset
//   wb_sel_i[1:0]     byte lanes: [0] = command port 0x20, [1] = data port 0x21
//   wb_dat_i[15:0]    write data: port 0x20 on [7:0], port 0x21 on [15:8]
//   wb_dat_o[15:0]    read data: {IMR, IRR or ISR}
//   wb_stb_i, wb_cyc_i, wb_we_i  Wishbone strobe / cycle / write enable
//   wb_ack_o          single-cycle acknowledge (stb & cyc)
//   irq_i[7:0]        rising-edge interrupt requests (irq_i[0] = timer 0)
//   intr_o            registered interrupt request to the CPU
//   inta_i            one-cycle interrupt acknowledge pulse
//   vector_o[7:0]     registered vector {base, level}
//
// Build option
//   PIC_AEOI_EN       when defined, ICW4 bit1 enables auto-EOI: an INTA then
//                     leaves ISR untouched. When undefined, aeoi stays 0.
module simple_pic (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic [7:0]  vector_o
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  imr_q, irr_q, isr_q;
  logic [7:0]  imr_d, irr_d, isr_d;
  logic [4:0]  base_q;
  logic        rsel_q;   // 0 = read IRR, 1 = read ISR
  logic        sngl_q;
  logic        ic4_q;
  logic        aeoi_q;
  logic [7:0]  sync1_q, sync2_q, prev_q;
  logic        intr_q;
  logic [7:0]  vector_q;

  // Lowest set index = highest priority (level 0 wins).
  function automatic logic [2:0] top_level(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic       wr_stb, wr_cmd, wr_data;
  logic [7:0] cmd, dat;
  logic       in_ready, icw1, ocw2, ocw3;
  logic [7:0] irq_edge, pending;
  logic [2:0] pend_lvl, isr_lvl;
  logic       pend_any, isr_any, inta_hit, isr_set_en;

  assign wb_ack_o = wb_stb_i & wb_cyc_i;
  assign wr_stb   = wb_ack_o & wb_we_i;
  // With both lanes selected only the command lane acts.
  assign wr_cmd   = wr_stb & wb_sel_i[0];
  assign wr_data  = wr_stb & wb_sel_i[1] & ~wb_sel_i[0];
  assign cmd      = wb_dat_i[7:0];
  assign dat      = wb_dat_i[15:8];

  assign in_ready = (state_q == READY);
  assign icw1     = wr_cmd & cmd[4];
  // OCW2/OCW3 are only honoured once initialisation has completed.
  assign ocw2     = wr_cmd & in_ready & ~cmd[4] & ~cmd[3];
  assign ocw3     = wr_cmd & in_ready & ~cmd[4] &  cmd[3];

  assign irq_edge = sync2_q & ~prev_q;
  assign pending  = irr_q & ~imr_q;
  assign pend_any = |pending;
  assign isr_any  = |isr_q;
  assign pend_lvl = top_level(pending);
  assign isr_lvl  = top_level(isr_q);
  assign inta_hit = inta_i & pend_any;
  assign isr_set_en = inta_hit & ~aeoi_q;

  always_comb begin
    // IRR: INTA clears the serviced bit, a fresh edge re-sets it (set wins),
    // and ICW1 overrides everything.
    irr_d = irr_q;
    if (inta_hit) irr_d[pend_lvl] = 1'b0;
    irr_d = irr_d | irq_edge;
    if (icw1) irr_d = 8'h00;

    // ISR: EOI clears first so that a same-cycle INTA set on the same bit wins.
    isr_d = isr_q;
    if (ocw2 && cmd[7:5] == 3'b001 && isr_any) isr_d[isr_lvl] = 1'b0;
    if (ocw2 && cmd[7:5] == 3'b011) isr_d[cmd[2:0]] = 1'b0;
    if (isr_set_en) isr_d[pend_lvl] = 1'b1;
    if (icw1) isr_d = 8'h00;

    imr_d = imr_q;
    if (icw1) imr_d = 8'h00;
    else if (wr_data && in_ready) imr_d = dat;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= READY;
      imr_q    <= 8'hFF;
      irr_q    <= 8'h00;
      isr_q    <= 8'h00;
      base_q   <= 5'b00001;
      rsel_q   <= 1'b0;
      sngl_q   <= 1'b0;
      ic4_q    <= 1'b0;
      aeoi_q   <= 1'b0;
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      prev_q   <= 8'h00;
      intr_q   <= 1'b0;
      vector_q <= 8'h08;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;

      // Request only when the best pending level beats everything in service.
      intr_q <= in_ready & pend_any & (~isr_any | (pend_lvl < isr_lvl));

      if (inta_i) begin
        vector_q <= inta_hit ? {base_q, pend_lvl} : {base_q, 3'd7};
      end

      if (icw1) begin
        rsel_q  <= 1'b0;
        sngl_q  <= cmd[1];
        ic4_q   <= cmd[0];
        state_q <= WAIT_ICW2;
      end else begin
        if (ocw3 && cmd[1]) rsel_q <= cmd[0];
        if (wr_data) begin
          case (state_q)
            WAIT_ICW2: begin
              base_q <= dat[7:3];
              if (!sngl_q)    state_q <= WAIT_ICW3;
              else if (ic4_q) state_q <= WAIT_ICW4;
              else            state_q <= READY;
            end
            WAIT_ICW3: begin
              // Cascade configuration is not supported; the byte is dropped.
              state_q <= ic4_q ? WAIT_ICW4 : READY;
            end
            WAIT_ICW4: begin
`ifdef PIC_AEOI_EN
              aeoi_q <= dat[1];
`else
              aeoi_q <= 1'b0;
`endif
              state_q <= READY;
            end
            default: state_q <= READY;
          endcase
        end
      end
    end
  end

  assign wb_dat_o = {imr_q, (rsel_q ? isr_q : irr_q)};
  assign intr_o   = intr_q;
  assign vector_o = vector_q;

endmodule

// File: tb/tb_simple_pic.sv
// Directed-vector scoreboard bench for simple_pic. Stimulus tasks push the
// expected value before driving; the monitor pops and compares whenever the
// DUT presents a read, a post-INTA vector, or a requested probe.
module tb_simple_pic;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        stb, cyc, we;
  logic        ack;
  logic [7:0]  irq;
  logic        intr;
  logic        inta;
  logic [7:0]  vec;

  logic        inta_seen = 1'b0;
  logic        probe_intr = 1'b0;
  logic        probe_vec = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam int K_READ = 0, K_VEC = 1, K_INTR = 2, K_VPROBE = 3;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  simple_pic dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_sel_i(sel),
    .wb_dat_i(dat_i),
    .wb_dat_o(dat_o),
    .wb_stb_i(stb),
    .wb_cyc_i(cyc),
    .wb_we_i (we),
    .wb_ack_o(ack),
    .irq_i   (irq),
    .intr_o  (intr),
    .inta_i  (inta),
    .vector_o(vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) inta_seen <= inta;

  task automatic push(input int kind, input logic [15:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [15:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output kind=%0d actual=%h required=none", kind, act);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || act !== e.exp) begin
        errors++;
        $display("FAIL %s: kind=%0d/%0d actual=%h required=%h", e.name, kind, e.kind, act, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack && !we) sb_check(K_READ, dat_o);
      if (inta_seen)  sb_check(K_VEC, {8'h00, vec});
      if (probe_intr) sb_check(K_INTR, {15'd0, intr});
      if (probe_vec)  sb_check(K_VPROBE, {8'h00, vec});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] d);
    @(posedge clk); #1;
    sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1; we = 1'b1;
    @(posedge clk); #1;
    sel = 2'b00; dat_i = 16'h0000; stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr0(input logic [7:0] d);
    wr(2'b01, {8'h00, d});
  endtask

  task automatic wr1(input logic [7:0] d);
    wr(2'b10, {d, 8'h00});
  endtask

  task automatic rd(input logic [15:0] exp, input string name);
    push(K_READ, exp, name);
    @(posedge clk); #1;
    sel = 2'b11; stb = 1'b1; cyc = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    sel = 2'b00; stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic do_inta(input logic [7:0] exp, input string name);
    push(K_VEC, {8'h00, exp}, name);
    @(posedge clk); #1 inta = 1'b1;
    @(posedge clk); #1 inta = 1'b0;
  endtask

  task automatic chk_intr(input logic exp, input string name);
    push(K_INTR, {15'd0, exp}, name);
    @(posedge clk); #1 probe_intr = 1'b1;
    @(posedge clk); #1 probe_intr = 1'b0;
  endtask

  task automatic chk_vec(input logic [7:0] exp, input string name);
    push(K_VPROBE, {8'h00, exp}, name);
    @(posedge clk); #1 probe_vec = 1'b1;
    @(posedge clk); #1 probe_vec = 1'b0;
  endtask

  // Pulse lines long enough to pass the synchronizer, then let IRR and
  // intr_o settle.
  task automatic irq_pulse(input logic [7:0] mask);
    @(posedge clk); #1 irq = mask;
    repeat (2) @(posedge clk);
    #1 irq = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 2'b00; dat_i = 16'h0000;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; irq = 8'h00; inta = 1'b0;
    do_reset();

    // Reset state
    rd(16'hFF00, "reset_read");
    chk_vec(8'h08, "reset_vector");
    chk_intr(1'b0, "reset_intr");

    // Single-mode init with ICW4, unmask level 0
    wr0(8'h13); wr1(8'h08); wr1(8'h01); wr1(8'hFE);
    rd(16'hFE00, "after_init");
    irq_pulse(8'h01);
    chk_intr(1'b1, "irq0_intr");
    rd(16'hFE01, "irq0_irr");
    do_inta(8'h08, "irq0_vector");
    chk_intr(1'b0, "irq0_intr_cleared");
    wr0(8'h0B);
    rd(16'hFE01, "irq0_isr");

    // Lower-priority request blocked by in-service level 0
    wr1(8'hF6);
    irq_pulse(8'h08);
    chk_intr(1'b0, "irq3_blocked");
    wr0(8'h20);
    chk_intr(1'b1, "irq3_after_eoi");
    rd(16'hF600, "isr_after_eoi");
    do_inta(8'h0B, "irq3_vector");
    rd(16'hF608, "irq3_isr");
    wr0(8'h20);

    // Two simultaneous edges, serviced in priority order
    wr1(8'h00);
    irq_pulse(8'h24);
    chk_intr(1'b1, "dual_intr");
    wr0(8'h0A);
    rd(16'h0024, "dual_irr");
    do_inta(8'h0A, "dual_first_vector");
    chk_intr(1'b0, "dual_blocked");
    wr0(8'h62);
    chk_intr(1'b1, "dual_after_specific_eoi");
    do_inta(8'h0D, "dual_second_vector");
    wr0(8'h20);

    // Spurious INTA, OCW3 without RR, both lanes selected
    irq_pulse(8'h02);
    do_inta(8'h09, "irq1_vector");
    do_inta(8'h0F, "spurious_vector");
    wr0(8'h08);
    rd(16'h0000, "ocw3_no_rr_keeps_irr");
    wr(2'b11, {8'h55, 8'h0B});
    rd(16'h0002, "dual_lane_isr_unchanged");
    chk_vec(8'h0F, "vector_held");
    wr0(8'h20);

    // Auto-EOI request in ICW4
    wr0(8'h13); wr1(8'h08); wr1(8'h03); wr1(8'hFE);
    irq_pulse(8'h01);
    do_inta(8'h08, "aeoi_vector");
    wr0(8'h0B);
`ifdef PIC_AEOI_EN
    rd(16'hFE00, "aeoi_isr");
    irq_pulse(8'h01);
    chk_intr(1'b1, "aeoi_second_intr");
`else
    rd(16'hFE01, "aeoi_isr");
    irq_pulse(8'h01);
    chk_intr(1'b0, "aeoi_second_intr");
`endif

    // Cascade-mode init: ICW3 discarded, no OCW during init, gated intr
    wr0(8'h10);
    irq_pulse(8'h04);
    chk_intr(1'b0, "init_gates_intr");
    wr1(8'h20);
    wr0(8'h0B);
    wr1(8'h77);
    chk_intr(1'b1, "post_icw3_intr");
    rd(16'h0004, "post_icw3_read");
    do_inta(8'h22, "new_base_vector");

    // Reset in the middle of initialisation
    wr0(8'h13);
    do_reset();
    rd(16'hFF00, "mid_init_reset_read");
    chk_vec(8'h08, "mid_init_reset_vector");
    chk_intr(1'b0, "mid_init_reset_intr");

    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 pending entries", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
